rr_entry_alloc_sched: RTL

Scheduler for an ENTRY_COUNT-deep circular entry buffer, such as an L1D miss/writeback tracking queue. Each cycle it arbitrates up to REQ_NUM requesters with a round-robin policy and allocates up to ALLOC_WIDTH entries in order at the tail. Allocated entries complete out of order via completion ports. Completed entries retire in order from the head, up to RETIRE_WIDTH per cycle. The block owns the head/tail/free-count bookkeeping and per-entry state.

---
 rtl/rr_entry_alloc_sched_if.sv | 36 +++
 rtl/rr_entry_alloc_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_entry_alloc_sched_if.sv
// Request/completion/retirement bundle of the round-robin entry allocator.
// The slave modport is the scheduler; the master modport is its environment.
interface rr_entry_alloc_sched_if #(
    parameter int ENTRY_COUNT  = 8,
    parameter int REQ_NUM      = 4,
    parameter int CPL_WIDTH    = 2,
    parameter int RETIRE_WIDTH = 2
);
    localparam int TAG_WIDTH = $clog2(ENTRY_COUNT);
    localparam int CNT_WIDTH = $clog2(ENTRY_COUNT + 1);

    logic [REQ_NUM-1:0]                     req_valid_i;
    logic [REQ_NUM-1:0]                     req_grant_o;
    logic [REQ_NUM-1:0][TAG_WIDTH-1:0]      req_tag_o;
    logic [CPL_WIDTH-1:0]                   cpl_valid_i;
    logic [CPL_WIDTH-1:0][TAG_WIDTH-1:0]    cpl_tag_i;
    logic                                   retire_ready_i;
    logic [RETIRE_WIDTH-1:0]                retire_valid_o;
    logic [RETIRE_WIDTH-1:0][TAG_WIDTH-1:0] retire_tag_o;
    logic                                   flush_i;
    logic [CNT_WIDTH-1:0]                   avail_cnt_o;
    logic                                   empty_o;
    logic                                   full_o;

    modport slave (
        input  req_valid_i, cpl_valid_i, cpl_tag_i, retire_ready_i, flush_i,
        output req_grant_o, req_tag_o, retire_valid_o, retire_tag_o,
               avail_cnt_o, empty_o, full_o
    );

    modport master (
        output req_valid_i, cpl_valid_i, cpl_tag_i, retire_ready_i, flush_i,
        input  req_grant_o, req_tag_o, retire_valid_o, retire_tag_o,
               avail_cnt_o, empty_o, full_o
    );
endinterface

// File: rtl/rr_entry_alloc_sched.sv
// Circular entry-buffer scheduler: round-robin allocation at the tail,
// out-of-order completion, in-order retirement from the head.
module rr_entry_alloc_sched_chk #(
    parameter int ENTRY_COUNT = 8,
    parameter int CPL_WIDTH   = 2,
    parameter int TAG_WIDTH   = 3,
    parameter int CNT_WIDTH   = 4
) (
    input logic                                clk,
    input logic                                rst,
    input logic                                flush_i,
    input logic [CPL_WIDTH-1:0]                cpl_valid_i,
    input logic [CPL_WIDTH-1:0][TAG_WIDTH-1:0] cpl_tag_i,
    input logic [ENTRY_COUNT-1:0]              alloc_q_i,
    input logic [CNT_WIDTH-1:0]                avail_q_i
);
    // Completions must target live entries; the free count stays in range.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            for (int j = 0; j < CPL_WIDTH; j++) begin
                if (cpl_valid_i[j]) begin
                    assert (int'(cpl_tag_i[j]) < ENTRY_COUNT && alloc_q_i[cpl_tag_i[j]])
                        else $warning("completion to unallocated entry %0d ignored", cpl_tag_i[j]);
                end
            end
            assert (int'(avail_q_i) <= ENTRY_COUNT)
                else $error("free count %0d out of range", avail_q_i);
        end
    end
endmodule

module rr_entry_alloc_sched #(
    parameter int ENTRY_COUNT  = 8,
    parameter int REQ_NUM      = 4,
    parameter int ALLOC_WIDTH  = 2,
    parameter int CPL_WIDTH    = 2,
    parameter int RETIRE_WIDTH = 2
) (
    input logic                   clk,
    input logic                   rst,
    rr_entry_alloc_sched_if.slave bus
);
    localparam int TAG_WIDTH = $clog2(ENTRY_COUNT);
    localparam int CNT_WIDTH = $clog2(ENTRY_COUNT + 1);
    localparam int PTR_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [TAG_WIDTH-1:0]                   head_q, head_d, tail_q, tail_d;
    logic [CNT_WIDTH-1:0]                   avail_q, avail_d;
    logic [PTR_WIDTH-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [ENTRY_COUNT-1:0]                 alloc_q, alloc_d, done_q, done_d;
    logic [REQ_NUM-1:0]                     grant_s;
    logic [REQ_NUM-1:0][TAG_WIDTH-1:0]      grant_tag_s;
    logic [RETIRE_WIDTH-1:0]                rv_s;
    logic [RETIRE_WIDTH-1:0][TAG_WIDTH-1:0] rt_s;
    int                                     grant_cnt_s, retire_cnt_s, last_idx_s, limit_s;

    function automatic logic [TAG_WIDTH-1:0] wrap_add(input logic [TAG_WIDTH-1:0] base, input int off);
        return TAG_WIDTH'((int'(base) + off) % ENTRY_COUNT);
    endfunction

    // Round-robin scan from rr_ptr_q; capacity is what was free at the start of the cycle.
    always_comb begin
        grant_s     = '0;
        grant_tag_s = '0;
        grant_cnt_s = 0;
        last_idx_s  = int'(rr_ptr_q);
        limit_s     = (int'(avail_q) < ALLOC_WIDTH) ? int'(avail_q) : ALLOC_WIDTH;
        for (int i = 0; i < REQ_NUM; i++) begin
            int   idx;
            logic take;
            idx  = (int'(rr_ptr_q) + i) % REQ_NUM;
            take = !rst && !bus.flush_i && bus.req_valid_i[idx] && (grant_cnt_s < limit_s);
            grant_s[idx]     = take;
            grant_tag_s[idx] = take ? wrap_add(tail_q, grant_cnt_s) : '0;
            last_idx_s       = take ? idx : last_idx_s;
            grant_cnt_s      = grant_cnt_s + (take ? 1 : 0);
        end
    end

    // Retirement lanes form a contiguous done prefix starting at the head.
    always_comb begin
        logic chain;
        rv_s         = '0;
        rt_s         = '0;
        retire_cnt_s = 0;
        chain        = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            rt_s[k] = wrap_add(head_q, k);
            chain   = chain & alloc_q[rt_s[k]] & done_q[rt_s[k]];
            rv_s[k] = chain;
            retire_cnt_s = retire_cnt_s +
                ((chain && bus.retire_ready_i && !bus.flush_i && !rst) ? 1 : 0);
        end
    end

    // Next-state bookkeeping: completions, then retirement clears, then new allocations.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        avail_d  = avail_q;
        rr_ptr_d = rr_ptr_q;
        alloc_d  = alloc_q;
        done_d   = done_q;
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            avail_d = CNT_WIDTH'(ENTRY_COUNT);
            alloc_d = '0;
            done_d  = '0;
        end else begin
            for (int j = 0; j < CPL_WIDTH; j++) begin
                done_d[bus.cpl_tag_i[j]] = done_d[bus.cpl_tag_i[j]] |
                                           (bus.cpl_valid_i[j] & alloc_q[bus.cpl_tag_i[j]]);
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                alloc_d[rt_s[k]] = alloc_d[rt_s[k]] & ~(rv_s[k] & bus.retire_ready_i);
                done_d[rt_s[k]]  = done_d[rt_s[k]]  & ~(rv_s[k] & bus.retire_ready_i);
            end
            for (int i = 0; i < REQ_NUM; i++) begin
                alloc_d[grant_tag_s[i]] = alloc_d[grant_tag_s[i]] | grant_s[i];
                done_d[grant_tag_s[i]]  = done_d[grant_tag_s[i]] & ~grant_s[i];
            end
            head_d   = wrap_add(head_q, retire_cnt_s);
            tail_d   = wrap_add(tail_q, grant_cnt_s);
            avail_d  = CNT_WIDTH'(int'(avail_q) + retire_cnt_s - grant_cnt_s);
            rr_ptr_d = (grant_cnt_s > 0) ? PTR_WIDTH'((last_idx_s + 1) % REQ_NUM) : rr_ptr_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            avail_q  <= CNT_WIDTH'(ENTRY_COUNT);
            rr_ptr_q <= '0;
            alloc_q  <= '0;
            done_q   <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            avail_q  <= avail_d;
            rr_ptr_q <= rr_ptr_d;
            alloc_q  <= alloc_d;
            done_q   <= done_d;
        end
    end

    assign bus.req_grant_o    = grant_s;
    assign bus.req_tag_o      = grant_tag_s;
    assign bus.retire_valid_o = rv_s;
    assign bus.retire_tag_o   = rt_s;
    assign bus.avail_cnt_o    = avail_q;
    assign bus.empty_o        = (avail_q == CNT_WIDTH'(ENTRY_COUNT));
    assign bus.full_o         = (avail_q == {CNT_WIDTH{1'b0}});

    rr_entry_alloc_sched_chk #(
        .ENTRY_COUNT(ENTRY_COUNT),
        .CPL_WIDTH  (CPL_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.flush_i),
        .cpl_valid_i(bus.cpl_valid_i),
        .cpl_tag_i  (bus.cpl_tag_i),
        .alloc_q_i  (alloc_q),
        .avail_q_i  (avail_q)
    );
endmodule
